// File: rtl/pe_cmd_seq.sv
`default_nettype none
//==============================================================================
// Module      : pe_cmd_seq
// Description : Command sequencer for the Life PE array. It accepts host
//               requests (write, read, step, clear) and drives the shared PE
//               command bus (cmd, rsel/csel, state_in, trigger). Read data
//               returns on a separate valid/ready response channel.
//               Optional feature macro: PE_SEQ_EARLY_STOP_EN. When it is
//               defined, a step ends early after the first generation in
//               which the OR-reduced PE activity is low.
// Revision    : 1.0 - initial release
//==============================================================================
module pe_cmd_seq #(
    parameter int ROWS          = 16,
    parameter int COLS          = 16,
    parameter int GEN_W         = 16,
    parameter int PE_STATE_BITS = 1,
    parameter int PE_CMD_BITS   = 2,
    parameter int ROW_W         = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int COL_W         = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [ROW_W-1:0]         req_row,
    input  logic [COL_W-1:0]         req_col,
    input  logic [PE_STATE_BITS-1:0] req_data,
    input  logic [GEN_W-1:0]         req_gens,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [PE_STATE_BITS-1:0] rsp_data,
    output logic                     rsp_err,
    output logic                     step_done,
    output logic [GEN_W-1:0]         gens_run,
    output logic [PE_CMD_BITS-1:0]   cmd,
    output logic                     trigger,
    output logic [ROWS-1:0]          rsel,
    output logic [COLS-1:0]          csel,
    output logic [PE_STATE_BITS-1:0] state_in,
    input  logic [PE_STATE_BITS-1:0] rd_data_i,
    input  logic                     active_i
);

    // PE opcodes and cell encodings shared with the array
    localparam logic [PE_CMD_BITS-1:0]   PE_CMD_NOP     = PE_CMD_BITS'(0);
    localparam logic [PE_CMD_BITS-1:0]   PE_CMD_WRITE   = PE_CMD_BITS'(1);
    localparam logic [PE_CMD_BITS-1:0]   PE_CMD_READ    = PE_CMD_BITS'(2);
    localparam logic [PE_CMD_BITS-1:0]   PE_CMD_PROCESS = PE_CMD_BITS'(3);
    localparam logic [PE_STATE_BITS-1:0] PE_STATE_DEAD  = '0;

    // Host request opcodes
    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;

    // Range limits widened by one bit so ROWS/COLS themselves are representable
    localparam logic [ROW_W:0] C_ROW_LIM = ROWS[ROW_W:0];
    localparam logic [COL_W:0] C_COL_LIM = COLS[COL_W:0];

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_CLR  = 3'd2,
        S_RD   = 3'd3,
        S_RDW  = 3'd4,
        S_RSP  = 3'd5,
        S_STEP = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [GEN_W-1:0]         cnt_q, cnt_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [PE_STATE_BITS-1:0] data_q, data_d;
    logic                     oob_q, oob_d;

    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [PE_STATE_BITS-1:0] rsp_data_q, rsp_data_d;
    logic                     rsp_err_q, rsp_err_d;
    logic                     step_done_q, step_done_d;
    logic [GEN_W-1:0]         gens_run_q, gens_run_d;
    logic [PE_CMD_BITS-1:0]   cmd_q, cmd_d;
    logic                     trigger_q, trigger_d;
    logic [ROWS-1:0]          rsel_q, rsel_d;
    logic [COLS-1:0]          csel_q, csel_d;
    logic [PE_STATE_BITS-1:0] state_in_q, state_in_d;

    logic                     w_accept;
    logic                     w_req_oob;
    logic                     w_step_end;
    logic [ROWS-1:0]          w_row_oh;
    logic [COLS-1:0]          w_col_oh;

    assign w_accept  = req_valid & req_ready_q;
    assign w_req_oob = ({1'b0, req_row} >= C_ROW_LIM) || ({1'b0, req_col} >= C_COL_LIM);

`ifdef PE_SEQ_EARLY_STOP_EN
    // An idle array cannot change any more, so the step ends after this generation
    assign w_step_end = (cnt_q == GEN_W'(1)) || !active_i;
`else
    logic w_unused_active;
    assign w_unused_active = active_i;
    assign w_step_end      = (cnt_q == GEN_W'(1));
`endif

    // Next-state, request latching, counters and response capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        data_d      = data_q;
        oob_d       = oob_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        gens_run_d  = gens_run_q;
        step_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    row_d  = req_row;
                    col_d  = req_col;
                    data_d = req_data;
                    cnt_d  = req_gens;
                    oob_d  = w_req_oob;
                    case (req_op)
                        OP_WRITE: if (!w_req_oob) state_d = S_WR;
                        OP_READ:  state_d = S_RD;
                        OP_STEP: begin
                            gens_run_d = '0;
                            if (req_gens == '0) step_done_d = 1'b1;
                            else                state_d     = S_STEP;
                        end
                        default:  state_d = S_CLR;
                    endcase
                end
            end
            S_WR, S_CLR: state_d = S_IDLE;
            S_RD:        state_d = S_RDW;
            S_RDW: begin
                // The PE registered its state_out on the previous edge
                rsp_data_d  = oob_q ? '0 : rd_data_i;
                rsp_err_d   = oob_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_STEP: begin
                cnt_d      = cnt_q - GEN_W'(1);
                gens_run_d = gens_run_q + GEN_W'(1);
                if (w_step_end) begin
                    step_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One-hot selects for the cell addressed in the upcoming state
    always_comb begin
        w_row_oh = '0;
        w_col_oh = '0;
        for (int r = 0; r < ROWS; r++) w_row_oh[r] = (row_d == ROW_W'(r));
        for (int c = 0; c < COLS; c++) w_col_oh[c] = (col_d == COL_W'(c));
    end

    // Bus outputs decoded from the upcoming state so they appear on the entry edge
    always_comb begin
        cmd_d       = PE_CMD_NOP;
        trigger_d   = 1'b0;
        rsel_d      = '0;
        csel_d      = '0;
        state_in_d  = PE_STATE_DEAD;
        req_ready_d = 1'b0;
        case (state_d)
            S_IDLE: req_ready_d = 1'b1;
            S_WR: begin
                cmd_d      = PE_CMD_WRITE;
                rsel_d     = w_row_oh;
                csel_d     = w_col_oh;
                state_in_d = data_d;
            end
            S_CLR: begin
                cmd_d  = PE_CMD_WRITE;
                rsel_d = '1;
                csel_d = '1;
            end
            S_RD: begin
                if (!oob_d) begin
                    cmd_d  = PE_CMD_READ;
                    rsel_d = w_row_oh;
                    csel_d = w_col_oh;
                end
            end
            S_STEP: begin
                cmd_d     = PE_CMD_PROCESS;
                trigger_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers; reset discards any in-flight request or response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            data_q      <= '0;
            oob_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            step_done_q <= 1'b0;
            gens_run_q  <= '0;
            cmd_q       <= PE_CMD_NOP;
            trigger_q   <= 1'b0;
            rsel_q      <= '0;
            csel_q      <= '0;
            state_in_q  <= PE_STATE_DEAD;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            data_q      <= data_d;
            oob_q       <= oob_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            step_done_q <= step_done_d;
            gens_run_q  <= gens_run_d;
            cmd_q       <= cmd_d;
            trigger_q   <= trigger_d;
            rsel_q      <= rsel_d;
            csel_q      <= csel_d;
            state_in_q  <= state_in_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign step_done = step_done_q;
    assign gens_run  = gens_run_q;
    assign cmd       = cmd_q;
    assign trigger   = trigger_q;
    assign rsel      = rsel_q;
    assign csel      = csel_q;
    assign state_in  = state_in_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_cmd_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_pe_cmd_seq
// Description : Scoreboard bench for pe_cmd_seq. Stimulus pushes expected bus
//               commands, read responses and step completions; a monitor pops
//               and compares them whenever the DUT presents them. A small PE
//               array stub answers READ commands from the cells the DUT wrote.
//               Honours PE_SEQ_EARLY_STOP_EN when computing step lengths.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pe_cmd_seq;

    localparam int ROWS  = 12;
    localparam int COLS  = 10;
    localparam int GEN_W = 8;
    localparam int RW    = 4;
    localparam int CW    = 4;

    localparam logic [1:0] C_NOP     = 2'd0;
    localparam logic [1:0] C_WRITE   = 2'd1;
    localparam logic [1:0] C_READ    = 2'd2;
    localparam logic [1:0] C_PROCESS = 2'd3;

    localparam logic [1:0] OP_WR  = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_ST  = 2'd2;
    localparam logic [1:0] OP_CLR = 2'd3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'd0;
    logic [RW-1:0]    req_row = '0;
    logic [CW-1:0]    req_col = '0;
    logic [0:0]       req_data = '0;
    logic [GEN_W-1:0] req_gens = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [0:0]       rsp_data;
    logic             rsp_err;
    logic             step_done;
    logic [GEN_W-1:0] gens_run;
    logic [1:0]       cmd;
    logic             trigger;
    logic [ROWS-1:0]  rsel;
    logic [COLS-1:0]  csel;
    logic [0:0]       state_in;
    logic [0:0]       rd_data_i;
    logic             active_i = 1'b1;

    always #5 clk = ~clk;

    pe_cmd_seq #(
        .ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .PE_STATE_BITS(1), .PE_CMD_BITS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_row(req_row), .req_col(req_col), .req_data(req_data), .req_gens(req_gens),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .step_done(step_done), .gens_run(gens_run),
        .cmd(cmd), .trigger(trigger), .rsel(rsel), .csel(csel), .state_in(state_in),
        .rd_data_i(rd_data_i), .active_i(active_i)
    );

    // PE array stub: stores cells written over the bus and registers a READ
    logic arr [ROWS][COLS];
    logic [0:0] rd_q;

    function automatic logic sel_or();
        logic v;
        v = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (rsel[r] && csel[c]) v = v | arr[r][c];
        return v;
    endfunction

    always @(posedge clk) begin
        if (cmd == C_WRITE)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (rsel[r] && csel[c]) arr[r][c] <= state_in[0];
        if (cmd == C_READ) rd_q <= sel_or();
    end
    assign rd_data_i = rd_q;

    // Scoreboard
    typedef struct {
        longint          t;
        logic [1:0]      c;
        logic [ROWS-1:0] rs;
        logic [COLS-1:0] cs;
        logic            sd;
        bit              chk_sel;
        bit              chk_sd;
    } cmd_exp_t;
    typedef struct {
        longint t;
        bit     chk_t;
        logic   d;
        logic   e;
    } rsp_exp_t;
    typedef struct {
        longint           t;
        logic [GEN_W-1:0] g;
    } step_exp_t;

    cmd_exp_t  exp_cmd[$];
    rsp_exp_t  exp_rsp[$];
    step_exp_t exp_step[$];

    logic ref_cells [ROWS][COLS];
    int   checks = 0;
    int   errors = 0;
    bit   hold_rsp = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic logic [ROWS-1:0] oh_r(input int r);
        logic [ROWS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic [COLS-1:0] oh_c(input int c);
        logic [COLS-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    function automatic cmd_exp_t mk_cmd(input longint t, input logic [1:0] c, input logic [ROWS-1:0] rs,
                                        input logic [COLS-1:0] cs, input logic sd, input bit cks, input bit ckd);
        cmd_exp_t e;
        e.t = t; e.c = c; e.rs = rs; e.cs = cs; e.sd = sd; e.chk_sel = cks; e.chk_sd = ckd;
        return e;
    endfunction

    task automatic monitor();
        cmd_exp_t  ce;
        rsp_exp_t  re;
        step_exp_t se;
        logic      pv;
        bit        ok;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cmd != C_NOP) begin
                    checks++;
                    if (exp_cmd.size() == 0) begin
                        errors++;
                        $display("FAIL cmd_unexpected t=%0t: got cmd=%0d rsel=%h csel=%h, expected no command",
                                 $time, cmd, rsel, csel);
                    end else begin
                        ce = exp_cmd.pop_front();
                        ok = ($time == ce.t) && (cmd == ce.c) && (trigger == (ce.c == C_PROCESS)) &&
                             (!ce.chk_sel || (rsel == ce.rs && csel == ce.cs)) &&
                             (!ce.chk_sd || state_in[0] == ce.sd);
                        if (!ok) begin
                            errors++;
                            $display("FAIL cmd_bus: got t=%0t cmd=%0d trig=%0d rsel=%h csel=%h sin=%0d, expected t=%0d cmd=%0d rsel=%h csel=%h sin=%0d",
                                     $time, cmd, trigger, rsel, csel, state_in, ce.t, ce.c, ce.rs, ce.cs, ce.sd);
                        end
                    end
                end else if (trigger) begin
                    chk("trigger_without_process", trigger, 0);
                end
                if (rsp_valid && !pv) begin
                    checks++;
                    if (exp_rsp.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected t=%0t: got data=%0d err=%0d, expected no response",
                                 $time, rsp_data, rsp_err);
                    end else begin
                        re = exp_rsp.pop_front();
                        if ((re.chk_t && $time != re.t) || rsp_data[0] != re.d || rsp_err != re.e) begin
                            errors++;
                            $display("FAIL rsp: got t=%0t data=%0d err=%0d, expected t=%0d data=%0d err=%0d",
                                     $time, rsp_data, rsp_err, re.t, re.d, re.e);
                        end
                    end
                end
                if (step_done) begin
                    checks++;
                    if (exp_step.size() == 0) begin
                        errors++;
                        $display("FAIL step_done_unexpected t=%0t: got gens_run=%0d, expected no pulse",
                                 $time, gens_run);
                    end else begin
                        se = exp_step.pop_front();
                        if ($time != se.t || gens_run != se.g) begin
                            errors++;
                            $display("FAIL step_done: got t=%0t gens_run=%0d, expected t=%0d gens_run=%0d",
                                     $time, gens_run, se.t, se.g);
                        end
                    end
                end
            end
            pv        = rsp_valid;
            rsp_ready = hold_rsp ? 1'b0 : 1'($urandom_range(0, 1));
        end
    endtask

    // Handshake one request; returns the accepting edge time or -1 on timeout
    task automatic send(input logic [1:0] op, input int row, input int col, input logic d,
                        input int gens, output longint ta);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", req_ready, 1);
            ta = -1;
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_row   = RW'(row);
        req_col   = CW'(col);
        req_data  = d;
        req_gens  = GEN_W'(gens);
        @(posedge clk);
        ta = $time;
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_row   = RW'($urandom);
        req_col   = CW'($urandom);
        req_data  = 1'($urandom);
        req_gens  = GEN_W'($urandom);
    endtask

    // Issue a request and record what the array and host must see for it
    task automatic issue(input logic [1:0] op, input int row, input int col, input logic d,
                         input int gens, input int stop_at);
        longint   ta;
        bit       oob;
        int       eff;
        rsp_exp_t re;
        step_exp_t se;
        send(op, row, col, d, gens, ta);
        if (ta < 0) return;
        oob = (row >= ROWS) || (col >= COLS);
        case (op)
            OP_WR: begin
                if (!oob) begin
                    exp_cmd.push_back(mk_cmd(ta + 5, C_WRITE, oh_r(row), oh_c(col), d, 1'b1, 1'b1));
                    ref_cells[row][col] = d;
                end
            end
            OP_RD: begin
                if (!oob) exp_cmd.push_back(mk_cmd(ta + 5, C_READ, oh_r(row), oh_c(col), 1'b0, 1'b1, 1'b0));
                re.t     = ta + 25;
                re.chk_t = !oob;
                re.d     = oob ? 1'b0 : ref_cells[row][col];
                re.e     = oob;
                exp_rsp.push_back(re);
            end
            OP_ST: begin
                eff = gens;
`ifdef PE_SEQ_EARLY_STOP_EN
                if (stop_at < gens) eff = stop_at + 1;
`endif
                for (int g = 0; g < eff; g++)
                    exp_cmd.push_back(mk_cmd(ta + 5 + 10 * g, C_PROCESS, '0, '0, 1'b0, 1'b0, 1'b0));
                se.t = ta + 5 + 10 * eff;
                se.g = GEN_W'(eff);
                exp_step.push_back(se);
                for (int j = 0; j < gens; j++) begin
                    active_i = (j != stop_at);
                    @(posedge clk);
                    #1;
                end
                active_i = 1'b1;
            end
            default: begin
                exp_cmd.push_back(mk_cmd(ta + 5, C_WRITE, '1, '1, 1'b0, 1'b1, 1'b1));
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) ref_cells[r][c] = 1'b0;
            end
        endcase
    endtask

    task automatic flush_and_release();
        exp_cmd.delete();
        exp_rsp.delete();
        exp_step.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        hold_rsp = 1'b0;
        #1;
        chk("req_ready_low_at_release", req_ready, 0);
        @(posedge clk);
        #1;
        chk("req_ready_after_release", req_ready, 1);
    endtask

    task automatic stimulus();
        longint ta;
        int     w;
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd", cmd, C_NOP);
        chk("rst_trigger", trigger, 0);
        chk("rst_rsel", rsel, 0);
        chk("rst_csel", csel, 0);
        chk("rst_state_in", state_in, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_step_done", step_done, 0);
        chk("rst_gens_run", gens_run, 0);
        rst_n = 1'b1;
        #1;
        chk("req_ready_before_first_edge", req_ready, 0);
        @(posedge clk);
        #1;
        chk("req_ready_first_cycle", req_ready, 1);

        // Directed cases
        issue(OP_CLR, 0, 0, 1'b0, 0, 0);
        issue(OP_WR, 2, 3, 1'b1, 0, 0);
        issue(OP_RD, 2, 3, 1'b0, 0, 0);
        issue(OP_RD, ROWS, 0, 1'b0, 0, 0);
        issue(OP_RD, 2, 3, 1'b0, 0, 0);
        issue(OP_WR, ROWS + 1, 1, 1'b1, 0, 0);
        issue(OP_WR, 1, COLS, 1'b1, 0, 0);
        issue(OP_RD, 1, COLS + 1, 1'b0, 0, 0);
        issue(OP_CLR, 0, 0, 1'b0, 0, 0);
        issue(OP_WR, 5, 4, 1'b1, 0, 0);
        issue(OP_WR, 5, 5, 1'b1, 0, 0);
        issue(OP_WR, 5, 6, 1'b1, 0, 0);
        issue(OP_ST, 0, 0, 1'b0, 5, 100);
        issue(OP_ST, 0, 0, 1'b0, 10, 0);
        issue(OP_ST, 0, 0, 1'b0, 0, 100);
        issue(OP_RD, 5, 5, 1'b0, 0, 0);
        issue(OP_WR, ROWS - 1, COLS - 1, 1'b1, 0, 0);
        issue(OP_RD, ROWS - 1, COLS - 1, 1'b0, 0, 0);

        // Reset during the third PROCESS cycle of a step
        send(OP_ST, 0, 0, 1'b0, 8, ta);
        if (ta >= 0) begin
            for (int g = 0; g < 3; g++)
                exp_cmd.push_back(mk_cmd(ta + 5 + 10 * g, C_PROCESS, '0, '0, 1'b0, 1'b0, 1'b0));
            #26;
            chk("step_busy_before_reset", cmd, C_PROCESS);
            rst_n = 1'b0;
            #1;
            chk("step_rst_cmd", cmd, C_NOP);
            chk("step_rst_trigger", trigger, 0);
            chk("step_rst_req_ready", req_ready, 0);
            flush_and_release();
        end

        // Reset while a response is held by rsp_ready=0
        hold_rsp = 1'b1;
        send(OP_RD, 5, 4, 1'b0, 0, ta);
        if (ta >= 0) begin
            exp_cmd.push_back(mk_cmd(ta + 5, C_READ, oh_r(5), oh_c(4), 1'b0, 1'b1, 1'b0));
            exp_rsp.push_back('{t: ta + 25, chk_t: 1'b1, d: ref_cells[5][4], e: 1'b0});
            #27;
            chk("rsp_held_before_reset", rsp_valid, 1);
            rst_n = 1'b0;
            #1;
            chk("rsp_rst_rsp_valid", rsp_valid, 0);
            chk("rsp_rst_cmd", cmd, C_NOP);
            chk("rsp_rst_trigger", trigger, 0);
            flush_and_release();
        end
        hold_rsp = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            issue(2'($urandom), $urandom_range(0, ROWS + 1), $urandom_range(0, COLS + 1),
                  1'($urandom), $urandom_range(0, 6), $urandom_range(0, 7));
        end

        // Drain and confirm nothing the bench expected went missing
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_req_ready", req_ready, 1);
        repeat (5) @(negedge clk);
        chk("pending_cmd", exp_cmd.size(), 0);
        chk("pending_rsp", exp_rsp.size(), 0);
        chk("pending_step", exp_step.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
